uart_tx_sched: RTL

Transmit scheduler that shares the single UART transmitter between several byte producers (CPU store port, debug dumper, and so on). It arbitrates the producers round-robin into a small FIFO. It then drains the FIFO into the UART with one write pulse per byte. The UART exposes no busy flag, so this block paces writes with a fixed byte-time counter that covers start, 8 data and 2 stop bits plus phase slack.

---
 rtl/uart_tx_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler feeding a paced, flagless UART write port
module uart_tx_sched #(
   parameter int NREQ        = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int BYTE_CYCLES = 10500
) (
   input  logic                        sys_clk_i,
   input  logic                        sys_rstn_i,
   input  logic [NREQ-1:0]             req_valid_i,
   input  logic [8*NREQ-1:0]           req_data_i,
   output logic [NREQ-1:0]             req_ready_o,
   output logic                        uart_wr_o,
   output logic [7:0]                  uart_dat_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
   output logic                        busy_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BYTE_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [RW-1:0] rr;
   logic [RW-1:0] gnt_idx;
   logic          gnt_any;
   logic [7:0]    gnt_data;

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [7:0]    mem [FIFO_DEPTH];
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [7:0]    dat_q;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // first valid requester at or after rr, wrapping; nothing granted while full
   always_comb begin
      int k;
      k           = 0;
      req_ready_o = '0;
      gnt_idx     = '0;
      gnt_any     = 1'b0;
      gnt_data    = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(rr) + i) % NREQ;
         if (!gnt_any && !full && req_valid_i[k]) begin
            gnt_any        = 1'b1;
            gnt_idx        = RW'(k);
            gnt_data       = req_data_i[8*k +: 8];
            req_ready_o[k] = 1'b1;
         end
      end
   end

   assign push = gnt_any;
   assign pop  = (state == ST_SEND);

   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         rr <= '0;
      end else if (push) begin
         rr <= (gnt_idx == RW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= gnt_data;
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // head byte is latched on entry to SEND so the UART sees it for the whole strobe
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
         dat_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state <= ST_SEND;
                  dat_q <= mem[rd_ptr[AW-1:0]];
               end
            end
            ST_SEND: begin
               state <= ST_WAIT;
               cnt   <= CW'(BYTE_CYCLES - 2);
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  if (!empty) begin
                     state <= ST_SEND;
                     dat_q <= mem[rd_ptr[AW-1:0]];
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign uart_wr_o    = pop;
   assign uart_dat_o   = dat_q;
   assign fifo_level_o = wr_ptr - rd_ptr;
   assign busy_o       = !empty || (state != ST_IDLE);

endmodule
